// File: rtl/adc_sclk_seq.sv
// ADC sample-clock sequencer: divides clk into an sclk burst (counted or continuous)
// with a per-period sample strobe, clean period-aligned stop and done pulse.
module adc_sclk_seq #(
    parameter int unsigned DIV_W       = 8,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned DIV_DEFAULT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [DIV_W-1:0] cfg_div,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic             sclk,
    output logic             sample_stb,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] samples_left
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   phase_q, phase_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   left_q, left_d;
    logic               sclk_q, sclk_d;
    logic               stb_q, stb_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               cfg_ready_q, cfg_ready_d;
    logic               period_end;
    logic               run_d;
    logic [DIV_W-1:0]   thr_d;

    // State register; reset forces an idle, quiet sequencer at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            div_q       <= DIV_W'(DIV_DEFAULT);
            cnt_q       <= '0;
            left_q      <= '0;
            sclk_q      <= 1'b0;
            stb_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            div_q       <= div_d;
            cnt_q       <= cnt_d;
            left_q      <= left_d;
            sclk_q      <= sclk_d;
            stb_q       <= stb_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_ready_q <= cfg_ready_d;
        end
    end

    // Next state; outputs are derived from the next phase so every output is a flop.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        left_d     = left_q;
        done_d     = 1'b0;
        period_end = (phase_q == div_q - DIV_W'(1));

        if (cfg_valid && cfg_ready_q) begin
            div_d = (cfg_div < DIV_W'(2)) ? DIV_W'(2) : cfg_div;
            cnt_d = cfg_count;
        end

        case (state_q)
            IDLE: begin
                if (start && !stop) begin
                    state_d = RUN;
                    phase_d = '0;
                    left_d  = cnt_d;
                end
            end
            RUN, STOPPING: begin
                phase_d = period_end ? '0 : phase_q + DIV_W'(1);
                if (stb_q && (cnt_q != '0)) begin
                    left_d = left_q - CNT_W'(1);
                end
                // Runs only ever end on a period boundary.
                if (period_end && (stop || (state_q == STOPPING) ||
                                   ((cnt_q != '0) && (left_d == '0)))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (stop) begin
                    state_d = STOPPING;
                end
            end
            default: state_d = IDLE;
        endcase

        run_d       = (state_d != IDLE);
        thr_d       = div_d - (div_d >> 1);
        sclk_d      = run_d && (phase_d >= thr_d);
        stb_d       = run_d && (phase_d == thr_d);
        busy_d      = run_d;
        cfg_ready_d = !run_d;
    end

    assign cfg_ready    = cfg_ready_q;
    assign sclk         = sclk_q;
    assign sample_stb   = stb_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign samples_left = left_q;

endmodule

// File: doc/adc_sclk_seq.md
ADC_SCLK_SEQ -- requirements
Module: adc_sclk_seq

Interface
REQ-001 SHALL have parameter DIV_W, default 8, width of the division ratio.
REQ-002 SHALL have parameter CNT_W, default 16, width of the burst sample count.
REQ-003 SHALL have parameter DIV_DEFAULT, default 10, division ratio loaded at reset.
REQ-004 clk  in  1  single clock; all logic on posedge clk.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 cfg_valid  in  1  configuration offer.
REQ-007 cfg_ready  out  1  configuration accepted when cfg_valid && cfg_ready.
REQ-008 cfg_div  in  DIV_W  requested sclk period in clk cycles.
REQ-009 cfg_count  in  CNT_W  samples per burst; 0 = continuous.
REQ-010 start  in  1  begin sequence (level sampled each cycle).
REQ-011 stop  in  1  request end of sequence.
REQ-012 sclk  out  1  divided ADC sample clock, flop-driven.
REQ-013 sample_stb  out  1  one-cycle pulse in the first high cycle of each sclk period.
REQ-014 busy  out  1  high in RUN and STOPPING.
REQ-015 done  out  1  one-cycle pulse on return to IDLE.
REQ-016 samples_left  out  CNT_W  remaining sample count.

Function
REQ-017 SHALL implement states IDLE, RUN, STOPPING.
REQ-018 cfg_ready SHALL be 1 only in IDLE; an accepted config SHALL load div_reg/cnt_reg the next cycle; cfg_valid outside IDLE SHALL have no effect.
REQ-019 cfg_div < 2 SHALL be loaded as 2.
REQ-020 IDLE: start=1, stop=0 -> RUN next cycle with phase=0, samples_left=cnt_reg; start and stop both 1 -> stay IDLE; a config handshake in the same cycle as start SHALL be applied to that run.
REQ-021 phase SHALL count 0..div_reg-1 in RUN/STOPPING and wrap to 0.
REQ-022 sclk SHALL be 1 exactly in cycles with phase >= div_reg - div_reg/2 (low ceil(div/2), high floor(div/2)); 0 in IDLE.
REQ-023 sample_stb SHALL be 1 exactly in cycles with phase == div_reg - div_reg/2; samples_left SHALL decrement by 1 at each sample_stb when cnt_reg != 0.
REQ-024 Counted burst: after the period with samples_left reaching 0 completes (phase == div_reg-1), SHALL enter IDLE with done=1 in the first IDLE cycle.
REQ-025 stop=1 in RUN -> STOPPING; STOPPING SHALL finish the current period, then IDLE with done pulse; no partial sclk period SHALL ever be emitted.
REQ-026 stop on the last cycle of a period SHALL end at that boundary (no extra period).
REQ-027 start in RUN/STOPPING and stop in IDLE SHALL be ignored.
REQ-028 Continuous mode (cnt_reg=0): samples_left SHALL hold 0; only stop ends the run.
REQ-029 div_reg SHALL be unchanged during a run; changes apply only from IDLE.

Reset
REQ-030 rst low SHALL immediately force IDLE, sclk=0, sample_stb=0, busy=0, done=0, cfg_ready=1, samples_left=0, phase=0, div_reg=DIV_DEFAULT, cnt_reg=0.
REQ-031 Reset asserted mid-run SHALL abort without a done pulse; sclk may be truncated only by reset.
REQ-032 After rst release, first action SHALL occur no earlier than the first posedge clk.

Verification
REQ-033 Reset: hold rst low 3 cycles -> sclk=0, busy=0, cfg_ready=1, done=0; start with no config -> period 10 (5 low, 5 high).
REQ-034 cfg_div=4, cfg_count=3, start -> sclk 0,0,1,1 x3; sample_stb at RUN cycles 2,6,10; samples_left 3->2->1->0; done at cycle 12; busy low at 12.
REQ-035 cfg_div=5, cfg_count=0, start; stop at phase 1 of period 2 -> period completes (3 low, 2 high), done at next phase-0 boundary, no sixth cycle of sclk.
REQ-036 cfg_div=0 -> loaded as 2; sclk alternates 0,1 every cycle; sample_stb every 2 cycles.
REQ-037 cfg_valid with cfg_div=6 during RUN -> cfg_ready=0, period stays 4; same offer held to IDLE -> accepted, next run period 6.
REQ-038 rst low at phase 2 of div=4 run -> sclk=0, busy=0 immediately, no done pulse, div_reg=10.
